// File: rtl/tile_blitter_if.sv
// Bus bundle for tile_blitter: CPU-side iomem port in, video write port out.
interface tile_blitter_if;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        vid_valid;
    logic [3:0]  vid_wstrb;
    logic [31:0] vid_addr;
    logic [31:0] vid_wdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata, vid_valid, vid_wstrb, vid_addr, vid_wdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata, vid_valid, vid_wstrb, vid_addr, vid_wdata
    );
endinterface

// File: rtl/tile_blitter.sv
// Tile-map rectangle fill engine and video-window pass-through bridge.
// Optional macro TILE_BLITTER_IRQ_EN: drive irq high for the one DONE cycle.
module tile_blitter #(
    parameter logic [3:0] TILE_BASE = 4'h2,
    parameter logic [3:0] REG_BASE  = 4'h4
) (
    input  logic          clk,
    input  logic          resetn,
    tile_blitter_if.slave bus,
    output logic          irq
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    function automatic logic [6:0] sat_size(input logic [6:0] v);
        return (v > 7'd64) ? 7'd64 : v;
    endfunction

    function automatic logic [31:0] tile_addr(input logic [5:0] x, input logic [5:0] y,
                                              input logic [5:0] c, input logic [5:0] r);
        logic [5:0] tx;
        logic [5:0] ty;
        tx = x + c;
        ty = y + r;
        return {8'h05, TILE_BASE, 6'h0, ty, tx, 2'b00};
    endfunction

    state_t      state, state_nxt;
    logic [5:0]  dst_x, dst_y, tile_val;
    logic [6:0]  size_w, size_h;
    logic        inc_mode, done_sticky;
    logic        reg_ready;
    logic [31:0] rdata, rd_val;
    logic [5:0]  col, row, cur_tile;
    logic [5:0]  col_nxt, row_nxt, tile_nxt;
    logic        last_col, last_row;
    logic        vld_p1;
    logic [31:0] addr_p1;
    logic [5:0]  tile_p1;

    logic       vid_sel, reg_sel, reg_acc, reg_wr, reg_rd;
    logic [1:0] reg_idx;
    logic       start_req, abort_req, busy, fire;

    assign vid_sel   = bus.iomem_valid && (bus.iomem_addr[23:20] < 4'h4);
    assign reg_sel   = bus.iomem_valid && (bus.iomem_addr[23:20] == REG_BASE);
    assign reg_acc   = reg_sel && !reg_ready;
    assign reg_wr    = reg_acc && (bus.iomem_wstrb != 4'b0000);
    assign reg_rd    = reg_acc && (bus.iomem_wstrb == 4'b0000);
    assign reg_idx   = bus.iomem_addr[3:2];
    assign start_req = reg_wr && (reg_idx == 2'd0) && bus.iomem_wstrb[0] && bus.iomem_wdata[0];
    assign abort_req = reg_wr && (reg_idx == 2'd0) && bus.iomem_wstrb[0] && bus.iomem_wdata[1];
    assign busy      = (state != IDLE);
    // A pending engine write only completes in a cycle the CPU is not using the video port.
    assign fire      = (state == RUN) && vld_p1 && !vid_sel;

    assign last_col = ({1'b0, col} == size_w - 7'd1);
    assign last_row = ({1'b0, row} == size_h - 7'd1);
    assign col_nxt  = last_col ? 6'd0 : col + 6'd1;
    assign row_nxt  = last_col ? row + 6'd1 : row;
    assign tile_nxt = inc_mode ? cur_tile + 6'd1 : cur_tile;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_req) state_nxt = (size_w == 7'd0 || size_h == 7'd0) ? DONE : RUN;
            RUN: begin
                if (abort_req)                       state_nxt = IDLE;
                else if (fire && last_col && last_row) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_val = 32'h0;
        case (reg_idx)
            2'd0: rd_val = {30'b0, done_sticky, busy};
            2'd1: rd_val = {18'b0, dst_y, 2'b0, dst_x};
            2'd2: rd_val = {17'b0, size_h, 1'b0, size_w};
            2'd3: rd_val = {23'b0, inc_mode, 2'b0, tile_val};
            default: rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dst_x <= '0; dst_y <= '0; size_w <= '0; size_h <= '0;
            tile_val <= '0; inc_mode <= 1'b0; done_sticky <= 1'b0;
            reg_ready <= 1'b0; rdata <= '0;
        end else begin
            reg_ready <= reg_acc;
            rdata     <= reg_rd ? rd_val : 32'h0;
            if (reg_wr && state == IDLE) begin
                case (reg_idx)
                    2'd1: begin
                        if (bus.iomem_wstrb[0]) dst_x <= bus.iomem_wdata[5:0];
                        if (bus.iomem_wstrb[1]) dst_y <= bus.iomem_wdata[13:8];
                    end
                    2'd2: begin
                        if (bus.iomem_wstrb[0]) size_w <= sat_size(bus.iomem_wdata[6:0]);
                        if (bus.iomem_wstrb[1]) size_h <= sat_size(bus.iomem_wdata[14:8]);
                    end
                    2'd3: begin
                        if (bus.iomem_wstrb[0]) tile_val <= bus.iomem_wdata[5:0];
                        if (bus.iomem_wstrb[1]) inc_mode <= bus.iomem_wdata[8];
                    end
                    default: ;
                endcase
            end
            // Completion takes priority over a status read clearing the flag in the same cycle.
            if (state == DONE)                   done_sticky <= 1'b1;
            else if (reg_rd && reg_idx == 2'd0) done_sticky <= 1'b0;
        end
    end

    // Stage p1: registered engine write, held until the video port is free
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1 <= 1'b0; col <= '0; row <= '0; cur_tile <= '0;
        end else begin
            case (state)
                IDLE: begin
                    vld_p1 <= 1'b0;
                    if (start_req) begin
                        col <= '0; row <= '0; cur_tile <= tile_val;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        vld_p1 <= 1'b0;
                    end else if (!vld_p1) begin
                        vld_p1  <= 1'b1;
                        addr_p1 <= tile_addr(dst_x, dst_y, col, row);
                        tile_p1 <= cur_tile;
                    end else if (fire) begin
                        if (last_col && last_row) begin
                            vld_p1 <= 1'b0;
                        end else begin
                            col      <= col_nxt;
                            row      <= row_nxt;
                            cur_tile <= tile_nxt;
                            addr_p1  <= tile_addr(dst_x, dst_y, col_nxt, row_nxt);
                            tile_p1  <= tile_nxt;
                        end
                    end
                end
                default: vld_p1 <= 1'b0;
            endcase
        end
    end

    always_comb begin
        bus.vid_valid = 1'b0;
        bus.vid_wstrb = 4'b0000;
        bus.vid_addr  = 32'h0;
        bus.vid_wdata = 32'h0;
        if (vid_sel) begin
            bus.vid_valid = 1'b1;
            bus.vid_wstrb = bus.iomem_wstrb;
            bus.vid_addr  = bus.iomem_addr;
            bus.vid_wdata = bus.iomem_wdata;
        end else if (vld_p1) begin
            bus.vid_valid = 1'b1;
            bus.vid_wstrb = 4'b0001;
            bus.vid_addr  = addr_p1;
            bus.vid_wdata = {26'b0, tile_p1};
        end
    end

    assign bus.iomem_ready = vid_sel | reg_ready;
    assign bus.iomem_rdata = rdata;

`ifdef TILE_BLITTER_IRQ_EN
    assign irq = (state == DONE);
`else
    assign irq = 1'b0;
`endif
endmodule
